// File: rtl/hs_to_stream_arbiter_if.sv
// Bundle of the ap_hs producer side and the AXI-Stream consumer side of
// hs_to_stream_arbiter.
//   in_hs / in_hs_ap_vld / in_hs_ap_ack : NUM_CH packed producer words with
//                                         per-channel valid and acknowledge
//   outStream_*                         : AXI-Stream master towards the
//                                         interconnect (tdata, tdest, tid,
//                                         tlast, tvalid, tready)
// Modports:
//   master : the arbiter (consumes the ap_hs words, drives the stream)
//   slave  : the environment (drives the ap_hs words, consumes the stream)
interface hs_to_stream_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int DEST_W = 5,
    parameter int ID_W   = 5
);
    logic [NUM_CH*(DATA_W+8)-1:0] in_hs;
    logic [NUM_CH-1:0]            in_hs_ap_vld;
    logic [NUM_CH-1:0]            in_hs_ap_ack;
    logic [DATA_W-1:0]            outStream_tdata;
    logic [DEST_W-1:0]            outStream_tdest;
    logic [ID_W-1:0]              outStream_tid;
    logic                         outStream_tlast;
    logic                         outStream_tvalid;
    logic                         outStream_tready;

    modport master (
        input  in_hs, in_hs_ap_vld, outStream_tready,
        output in_hs_ap_ack, outStream_tdata, outStream_tdest, outStream_tid,
               outStream_tlast, outStream_tvalid
    );

    modport slave (
        output in_hs, in_hs_ap_vld, outStream_tready,
        input  in_hs_ap_ack, outStream_tdata, outStream_tdest, outStream_tid,
               outStream_tlast, outStream_tvalid
    );
endinterface

// File: rtl/hs_to_stream_arbiter.sv
// Multi-channel ap_hs to AXI-Stream adapter. NUM_CH HLS ap_hs producers are
// arbitrated round-robin, with the grant locked for the duration of a packet,
// and the accepted words are buffered in a DEPTH-entry FIFO that drives a
// single AXI-Stream master.
//
// Ports:
//   clk        : clock
//   aresetn    : asynchronous active-low reset
//   accID      : accelerator ID, driven onto tid
//   bus        : hs_to_stream_arbiter_if.master (ap_hs words in, stream out)
//   fifo_count : current FIFO occupancy (0..DEPTH)
//
// Producer word layout: bit 0 last, bit 1 reserved, [DEST_W+1:2] dest,
// [DATA_W+7:8] data; any other header bits are ignored.
//
// Arbiter states:
//   state    | meaning
//   UNLOCKED | between packets; cur may move to the next valid channel
//   LOCKED   | mid-packet; only channel cur can be acknowledged
module hs_to_stream_arbiter #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int DEST_W = 5,
    parameter int ID_W   = 5,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [ID_W-1:0]        accID,
    hs_to_stream_arbiter_if.master bus,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int WORD_W  = DATA_W + 8;
    localparam int ENTRY_W = DATA_W + DEST_W + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CUR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    arb_state_t         state_q, state_d;
    logic [CUR_W-1:0]   cur_q, cur_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    logic               full;
    logic               tvalid;
    logic               push;
    logic               pop;
    logic               cur_vld;
    logic [NUM_CH-1:0]  ack;
    logic [CUR_W-1:0]   scan_cur;
    logic [ENTRY_W-1:0] sel_entry;
    logic [ENTRY_W-1:0] head;
    logic               unused_in_hs;

    // Handshake: an ack is the transfer itself, so push follows ack directly.
    // aresetn is folded in so the acks drop the moment reset asserts.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        tvalid  = (count_q != '0);
        pop     = tvalid && bus.outStream_tready;
        ack     = '0;
        cur_vld = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(cur_q) == c) begin
                cur_vld = bus.in_hs_ap_vld[c];
                ack[c]  = aresetn && bus.in_hs_ap_vld[c] && !full;
            end
        end
        push = |ack;
    end

    // Granted channel's word, repacked as a FIFO entry {data, dest, last}.
    always_comb begin
        sel_entry = {bus.in_hs[int'(cur_q)*WORD_W + 8 +: DATA_W],
                     bus.in_hs[int'(cur_q)*WORD_W + 2 +: DEST_W],
                     bus.in_hs[int'(cur_q)*WORD_W]};
    end

    // Next valid channel after cur, wrapping, cur itself considered last.
    // Offsets are visited farthest-first so the nearest valid channel is the
    // one that sticks; if nothing is valid cur is kept.
    always_comb begin
        scan_cur = cur_q;
        for (int k = NUM_CH; k >= 1; k--) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (c == (int'(cur_q) + k) % NUM_CH && bus.in_hs_ap_vld[c]) begin
                    scan_cur = CUR_W'(c);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        if (push) begin
            if (sel_entry[0]) begin
                state_d = UNLOCKED;
                cur_d   = scan_cur;
            end else begin
                state_d = LOCKED;
            end
        end else if (!full && state_q == UNLOCKED && !cur_vld) begin
            // Switching grant costs one idle cycle: the new channel is
            // acknowledged only once cur points at it.
            cur_d = scan_cur;
        end
    end

    // No pass-through when full: push is already blocked by the ack gating,
    // so a same-cycle pop only frees the slot for the next cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= UNLOCKED;
            cur_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.in_hs_ap_ack     = ack;
    assign bus.outStream_tvalid = tvalid;
    assign bus.outStream_tdata  = tvalid ? head[ENTRY_W-1 -: DATA_W] : '0;
    assign bus.outStream_tdest  = tvalid ? head[DEST_W:1] : '0;
    assign bus.outStream_tlast  = tvalid && head[0];
    assign bus.outStream_tid    = accID;
    assign fifo_count           = count_q;

    // Reserved and spare header bits carry no meaning.
    assign unused_in_hs = ^bus.in_hs;
endmodule

// File: tb/tb_hs_to_stream_arbiter.sv
module tb_hs_to_stream_arbiter;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 64;
    localparam int DEST_W = 5;
    localparam int ID_W   = 5;
    localparam int DEPTH  = 4;
    localparam int WORD_W = DATA_W + 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              last;
        logic [1:0]        junk;
    } word_t;

    logic             clk = 1'b0;
    logic             aresetn;
    logic [ID_W-1:0]  accID;
    logic [CNT_W-1:0] fifo_count;

    hs_to_stream_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W), .ID_W(ID_W)) bus ();

    hs_to_stream_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEST_W(DEST_W), .ID_W(ID_W), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .accID     (accID),
        .bus       (bus.master),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // producers: per-channel word queues; pres = vld currently held
    word_t             chq [NUM_CH][$];
    logic [NUM_CH-1:0] pres;
    bit                rand_mode;

    // reference model: FIFO contents in acceptance order plus grant/lock
    word_t             mq [$];
    int                m_cur;
    bit                m_lock;
    logic [NUM_CH-1:0] exp_ack;

    // observations
    int                ack_log [$];
    word_t             out_log [$];
    word_t             sent [$];
    logic [NUM_CH-1:0] obs_ack;
    logic [CNT_W-1:0]  obs_count;
    int                n;
    int                len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] t, input logic l);
        word_t w;
        w.data = d;
        w.dest = t;
        w.last = l;
        w.junk = 2'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic apply_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            word_t w;
            w = (chq[c].size() > 0) ? chq[c][0] : word_t'(0);
            bus.in_hs[c*WORD_W +: WORD_W] = {w.data, w.junk[1], w.dest, w.junk[0], w.last};
            bus.in_hs_ap_vld[c] = pres[c];
        end
    endtask

    task automatic present();
        for (int c = 0; c < NUM_CH; c++)
            if (!pres[c] && chq[c].size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0))
                pres[c] = 1'b1;
        apply_inputs();
    endtask

    function automatic int scan_next();
        for (int k = 1; k <= NUM_CH; k++)
            if (pres[(m_cur + k) % NUM_CH]) return (m_cur + k) % NUM_CH;
        return m_cur;
    endfunction

    // one clock: compare at negedge, advance model at posedge, re-drive at +1
    task automatic step();
        bit    full;
        word_t w;
        @(negedge clk);
        exp_ack = '0;
        if (pres[m_cur] && mq.size() < DEPTH) exp_ack[m_cur] = 1'b1;
        obs_ack   = bus.in_hs_ap_ack;
        obs_count = fifo_count;
        check("ack", 64'(bus.in_hs_ap_ack), 64'(exp_ack));
        check("tvalid", 64'(bus.outStream_tvalid), 64'(mq.size() != 0));
        check("tdata", bus.outStream_tdata, mq.size() != 0 ? mq[0].data : 64'd0);
        check("tdest", 64'(bus.outStream_tdest), mq.size() != 0 ? 64'(mq[0].dest) : 64'd0);
        check("tlast", 64'(bus.outStream_tlast), mq.size() != 0 ? 64'(mq[0].last) : 64'd0);
        check("tid", 64'(bus.outStream_tid), 64'(accID));
        check("fifo_count", 64'(fifo_count), 64'(mq.size()));
        for (int c = 0; c < NUM_CH; c++) if (bus.in_hs_ap_ack[c]) ack_log.push_back(c);
        if (bus.outStream_tvalid && bus.outStream_tready) begin
            w = '0;
            w.data = bus.outStream_tdata;
            w.dest = bus.outStream_tdest;
            w.last = bus.outStream_tlast;
            out_log.push_back(w);
        end
        @(posedge clk);
        full = (mq.size() == DEPTH);
        if (mq.size() != 0 && bus.outStream_tready) void'(mq.pop_front());
        if (exp_ack != 0) begin
            w = chq[m_cur][0];
            mq.push_back(w);
            if (w.last) begin
                m_lock = 0;
                m_cur  = scan_next();
            end else begin
                m_lock = 1;
            end
        end else if (!full && !m_lock && !pres[m_cur]) begin
            m_cur = scan_next();
        end
        #1;
        for (int c = 0; c < NUM_CH; c++)
            if (exp_ack[c]) begin
                void'(chq[c].pop_front());
                pres[c] = 1'b0;
            end
        present();
    endtask

    task automatic clear_logs();
        ack_log.delete();
        out_log.delete();
        sent.delete();
    endtask

    task automatic check_out(input string tag);
        check({tag, "_count"}, 64'(out_log.size()), 64'(sent.size()));
        for (int i = 0; i < sent.size() && i < out_log.size(); i++) begin
            check({tag, "_data"}, out_log[i].data, sent[i].data);
            check({tag, "_dest"}, 64'(out_log[i].dest), 64'(sent[i].dest));
            check({tag, "_last"}, 64'(out_log[i].last), 64'(sent[i].last));
        end
    endtask

    initial begin
        // reset, with ch0 already presenting: acks must stay low under reset
        aresetn = 1'b0;
        accID = 5'h0A;
        rand_mode = 0;
        pres = '0;
        m_cur = 0;
        m_lock = 0;
        bus.outStream_tready = 1'b1;
        chq[0].push_back(mk(64'h1122334455667788, 5'd3, 1'b1));
        sent.push_back(chq[0][0]);
        pres[0] = 1'b1;
        apply_inputs();
        #2;
        check("rst_ack", 64'(bus.in_hs_ap_ack), 64'd0);
        check("rst_tvalid", 64'(bus.outStream_tvalid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_tdata", bus.outStream_tdata, 64'd0);
        check("rst_tdest", 64'(bus.outStream_tdest), 64'd0);
        check("rst_tlast", 64'(bus.outStream_tlast), 64'd0);
        check("rst_tid", 64'(bus.outStream_tid), 64'h0A);
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // single word
        for (int i = 0; i < 4; i++) step();
        check("single_acks", 64'(ack_log.size()), 64'd1);
        check("single_ack_ch", 64'(ack_log[0]), 64'd0);
        check_out("single");
        check("single_tdata_lit", out_log[0].data, 64'h1122334455667788);

        // packet lock: ch1 waits for ch0's 3-word packet
        clear_logs();
        for (int j = 0; j < 3; j++) chq[0].push_back(mk({$urandom, $urandom}, DEST_W'(4 + j), j == 2));
        chq[1].push_back(mk({$urandom, $urandom}, 5'd7, 1'b1));
        for (int j = 0; j < 3; j++) sent.push_back(chq[0][j]);
        sent.push_back(chq[1][0]);
        present();
        for (int i = 0; i < 10; i++) step();
        check("lock_acks", 64'(ack_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check("lock_ack_ch", 64'(ack_log[i]), (i == 3) ? 64'd1 : 64'd0);
        check_out("lock");

        // round-robin: prime cur back to ch0, then both stream single words
        chq[0].push_back(mk({$urandom, $urandom}, 5'd1, 1'b1));
        present();
        for (int i = 0; i < 4; i++) step();
        clear_logs();
        for (int j = 0; j < 4; j++) begin
            chq[0].push_back(mk({$urandom, $urandom}, 5'd1, 1'b1));
            chq[1].push_back(mk({$urandom, $urandom}, 5'd2, 1'b1));
        end
        present();
        for (int i = 0; i < 14; i++) step();
        check("rr_acks", 64'(ack_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++) check("rr_ack_ch", 64'(ack_log[i]), 64'(i % 2));
        check("rr_beats", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check("rr_dest", 64'(out_log[i].dest), (i % 2 == 0) ? 64'd1 : 64'd2);

        // back-pressure
        clear_logs();
        bus.outStream_tready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chq[0].push_back(mk({$urandom, $urandom}, DEST_W'($urandom), 1'b1));
            sent.push_back(chq[0][j]);
        end
        present();
        n = 0;
        while (fifo_count != CNT_W'(DEPTH) && n < 20) begin
            step();
            n++;
        end
        check("bp_fill_in_time", 64'(n < 20), 64'd1);
        step();
        step();
        check("bp_full_count", 64'(obs_count), 64'(DEPTH));
        check("bp_full_ack", 64'(obs_ack), 64'd0);
        check("bp_acks", 64'(ack_log.size()), 64'd4);
        bus.outStream_tready = 1'b1;
        step();
        check("bp_pop_ack", 64'(obs_ack), 64'd0);
        bus.outStream_tready = 1'b0;
        step();
        check("bp_after_pop_count", 64'(obs_count), 64'd3);
        check("bp_after_pop_ack", 64'(obs_ack), 64'b01);
        step();
        check("bp_refill_count", 64'(obs_count), 64'(DEPTH));
        check("bp_refill_ack", 64'(obs_ack), 64'd0);
        bus.outStream_tready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_out("bp");

        // idle switch: only ch1 valid while cur=0
        clear_logs();
        chq[1].push_back(mk({$urandom, $urandom}, 5'd9, 1'b1));
        sent.push_back(chq[1][0]);
        present();
        step();
        check("idle_first_ack", 64'(obs_ack), 64'd0);
        step();
        check("idle_second_ack", 64'(obs_ack), 64'b10);
        for (int i = 0; i < 3; i++) step();
        check("idle_acks", 64'(ack_log.size()), 64'd1);
        check_out("idle");

        // async reset mid-packet with two words buffered
        clear_logs();
        bus.outStream_tready = 1'b0;
        for (int j = 0; j < 3; j++) chq[0].push_back(mk({$urandom, $urandom}, 5'd5, j == 2));
        present();
        n = 0;
        while (fifo_count != CNT_W'(2) && n < 20) begin
            step();
            n++;
        end
        check("arst_fill_in_time", 64'(n < 20), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(bus.outStream_tvalid), 64'd0);
        check("arst_count", 64'(fifo_count), 64'd0);
        check("arst_ack", 64'(bus.in_hs_ap_ack), 64'd0);
        check("arst_tdata", bus.outStream_tdata, 64'd0);
        mq.delete();
        m_cur = 0;
        m_lock = 0;
        chq[0].delete();
        pres = '0;
        apply_inputs();
        @(posedge clk);
        #1;
        check("arst_hold_count", 64'(fifo_count), 64'd0);
        clear_logs();
        chq[1].push_back(mk({$urandom, $urandom}, 5'd12, 1'b1));
        sent.push_back(chq[1][0]);
        bus.outStream_tready = 1'b1;
        present();
        aresetn = 1'b1;
        step();
        check("arst_idle_ack", 64'(obs_ack), 64'd0);
        step();
        check("arst_ch1_ack", 64'(obs_ack), 64'b10);
        for (int i = 0; i < 3; i++) step();
        check_out("arst");

        // randomized traffic against the model
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (chq[c].size() == 0 && $urandom_range(0, 2) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++)
                        chq[c].push_back(mk({$urandom, $urandom}, DEST_W'($urandom), j == len - 1));
                end
            end
            bus.outStream_tready = 1'($urandom_range(0, 1));
            present();
            step();
        end
        bus.outStream_tready = 1'b1;
        for (int i = 0; i < 60; i++) step();
        check("rand_drained", 64'(fifo_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hs_to_stream_arbiter.md
Name: hs_to_stream_arbiter

Overview:
- Multi-channel successor of the single-channel ap_hs-to-AXI-Stream adapter.
- Accepts NUM_CH HLS ap_hs output words and arbitrates between them round-robin, locked per packet.
- Buffers accepted words in a DEPTH-entry FIFO and drives one AXI-Stream master towards the accelerator interconnect.
- The FIFO decouples HLS producers from interconnect back-pressure.

Parameters:
- NUM_CH, 2, number of ap_hs input channels (1..8).
- DATA_W, 64, stream payload width.
- DEST_W, 5, tdest width (1..6).
- ID_W, 5, accelerator ID / tid width.
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- accID  in  ID_W  accelerator ID, driven onto tid
- in_hs  in  NUM_CH*(DATA_W+8)  packed channel words; channel c at [c*(DATA_W+8) +: DATA_W+8]
- in_hs_ap_vld  in  NUM_CH  per-channel valid
- in_hs_ap_ack  out  NUM_CH  per-channel acknowledge
- outStream_tdata  out  DATA_W  payload
- outStream_tdest  out  DEST_W  destination
- outStream_tid  out  ID_W  = accID
- outStream_tlast  out  1  end of packet
- outStream_tvalid  out  1  FIFO non-empty
- outStream_tready  in  1  downstream ready
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: asynchronous, active-low. Clears FIFO pointers, count, cur (grant index) and lock. No stray pushes or pops on deassertion.
  - After reset: tvalid=0, fifo_count=0, acks=0, tdata/tdest/tlast=0. tid always equals accID.
- Channel word format: bit 0 last; bit 1 reserved; [DEST_W+1:2] dest; [DATA_W+7:8] data. Unused header bits ignored.
- Ack (combinational): in_hs_ap_ack[c] = aresetn && c==cur && in_hs_ap_vld[c] && !full.
  - An ack is a transfer in that same cycle; the word is pushed on that edge.
  - A producer holds vld and data until acked.
- Arbiter states: UNLOCKED (lock=0) and LOCKED (lock=1, cur fixed). Transitions on each edge:
  - Accept with last=0 -> LOCKED; cur holds.
  - Accept with last=1 -> UNLOCKED; cur <= first channel with vld=1 scanning cur+1, cur+2, ... wrapping, cur itself last. If none is valid, cur holds.
  - UNLOCKED with vld[cur]=0 -> cur <= next valid channel by the same scan; holds if none. This costs one idle cycle per switch.
  - LOCKED with vld[cur]=0 -> wait; other channels are never acked mid-packet.
  - full -> no accept; state and cur hold.
- FIFO:
  - count 0..DEPTH; full = count==DEPTH.
  - Each entry stores {data, dest, last}.
  - tvalid = count!=0. tdata/tdest/tlast = head entry when tvalid, else 0.
  - Pop when tvalid && tready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, no push, even if a pop occurs that cycle (no pass-through); the ack is deferred to the next cycle.
  - Pointers wrap modulo DEPTH.
- Latency: a word acked in cycle N is visible with tvalid=1 in cycle N+1 if the FIFO was empty. Throughput is one word per cycle while not full.
- Ordering: words leave in acceptance order. Packets from different channels never interleave on the stream.
- Reset mid-packet: buffered words are discarded, lock is cleared, and cur returns to 0. The partial packet is lost; upstream is responsible.

Test Plan:
- Single word: ch0 presents data=0x1122334455667788, dest=3, last=1, tready=1.
  - ack[0] pulses exactly one cycle.
  - Next cycle: tvalid=1, tdata=0x1122334455667788, tdest=3, tlast=1, tid=accID=0x0A.
- Packet lock: ch0 sends 3-word packet (last only on word 3) while ch1 holds vld.
  - ch1 receives no ack until ch0's word 3 is accepted.
  - Stream shows ch0 w1,w2,w3, then ch1's word.
- Round-robin: both channels stream single-word packets continuously.
  - Acks alternate ch0,ch1,ch0,ch1.
  - Stream dest sequence matches the programmed dests 1,2,1,2.
- Back-pressure, DEPTH=4: tready=0 with ch0 continuously valid.
  - 4 acks, then fifo_count=4 and acks stop.
  - With tready=1 for one cycle: pop, count=3, one new ack the following cycle, count back to 4.
- Idle switch: only ch1 valid while cur=0.
  - One idle cycle, then ack[1]; no ack[0] ever asserted.
- Async reset: assert aresetn=0 mid-packet with count=2.
  - tvalid, fifo_count and acks drop to 0 immediately, without waiting for a clock edge.
  - After release, ch1 single word is accepted normally (lock cleared).
